datmem_arbiter: RTL and testbench
=================================

DATMEM_ARBITER -- requirements
Module: datmem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 32, SHALL set the address and data width.
REQ-002 Parameter ALENGTH, default 128, SHALL set the number of data-memory words; valid addresses are 0..ALENGTH-1.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Req0/Req1  input  1  SHALL be the access request from port n (0 = CPU, 1 = DMA).
REQ-006 We0/We1  input  1  SHALL be the write (1) or read (0) select for port n.
REQ-007 Addr0/Addr1  input  AWIDTH  SHALL be the word address for port n.
REQ-008 WDat0/WDat1  input  AWIDTH  SHALL be the write data for port n.
REQ-009 Gnt0/Gnt1  output  1  SHALL be a one-cycle pulse meaning port n's request was accepted.
REQ-010 RVal0/RVal1  output  1  SHALL be a one-cycle pulse meaning port n's access completed.
REQ-011 RDat0/RDat1  output  AWIDTH  SHALL carry the read data for port n.
REQ-012 Err0/Err1  output  1  SHALL flag an out-of-range access, valid while RValn=1.
REQ-013 MemWE  output  1  SHALL be the data-memory write enable.
REQ-014 MemAddr  output  AWIDTH  SHALL be the data-memory address.
REQ-015 MemWDat  output  AWIDTH  SHALL be the data-memory write data.
REQ-016 MemRDat  input  AWIDTH  SHALL be the data-memory read data, valid one cycle after MemAddr is presented.

Function
REQ-017 FSM states: IDLE, BUSY, RESP; transitions are IDLE->BUSY when Req0|Req1, else stay in IDLE; BUSY->RESP unconditionally; RESP->IDLE unconditionally.
REQ-018 In IDLE the winner SHALL be chosen as follows: only one port requesting, that port wins; both requesting, the port not in LastGnt wins (round-robin).
REQ-019 On IDLE->BUSY the block SHALL latch the winner's We, Addr and WDat, update LastGnt to the winner, and assert Gntn for exactly the BUSY cycle.
REQ-020 A requester SHALL hold Req, We, Addr and WDat stable until it sees Gnt; the block ignores those inputs outside IDLE.
REQ-021 In BUSY, MemAddr and MemWDat SHALL carry the latched values, and MemWE = latched We AND in-range AND NOT Rst.
REQ-022 The in-range condition is latched Addr < ALENGTH, compared at the full AWIDTH width with no truncation.
REQ-023 Outside BUSY, MemWE SHALL be 0; MemAddr and MemWDat SHALL hold their last values.
REQ-024 At the end of RESP, the block SHALL register the result, so that in the following cycle RValn=1 for the winner only.
REQ-025 Read, in range: RDatn SHALL equal MemRDat sampled in RESP, with Errn=0.
REQ-026 Write, in range: RDatn SHALL keep its previous value, with Errn=0.
REQ-027 Out of range (read or write): the memory SHALL NOT be written, RDatn=0 and Errn=1.
REQ-028 Latency SHALL be: Req sampled in IDLE at cycle T, Gnt at T+1, RVal at T+3; peak throughput is one access per 3 cycles.
REQ-029 The RVal cycle coincides with IDLE, so a Req held high then SHALL count as a new request and is arbitrated normally.
REQ-030 Errn SHALL hold until the next RValn for that port; RDatn SHALL hold until overwritten.
REQ-031 The non-winning port's Gnt, RVal, RDat and Err SHALL be unaffected by the other port's access.

Reset
REQ-032 When Rst=1 at a rising edge, the next state SHALL be: FSM in IDLE, LastGnt=1, Gnt0/1=0, RVal0/1=0, RDat0/1=0, Err0/1=0, MemAddr=0, MemWDat=0.
REQ-033 MemWE SHALL be 0 in any cycle with Rst=1.
REQ-034 Rst in BUSY or RESP SHALL abort the in-flight access: no memory write, no RVal.
REQ-035 The first arbitration after reset with both ports requesting SHALL grant port 0.

Verification
REQ-036 Reset, then Req0=1, We0=1, Addr0=5, WDat0=0xDEADBEEF -> Gnt0 at T+1, MemWE=1 with MemAddr=5 in the same cycle, RVal0=1 and Err0=0 at T+3.
REQ-037 Then Req0=1, We0=0, Addr0=5 -> RVal0=1 and RDat0=0xDEADBEEF at T+3, with MemWE=0 throughout.
REQ-038 Req0 and Req1 both held high for 4 accesses after reset -> grant order 0,1,0,1, with every Gnt pulse 3 cycles apart.
REQ-039 Req1=1, We1=1, Addr1=128 (also Addr1=0x80000005) -> MemWE stays 0, RVal1=1, Err1=1, RDat1=0.
REQ-040 Write in progress with Rst=1 during BUSY -> MemWE=0 that cycle, no RVal, all outputs 0; a subsequent read of that address returns the old data.

Source files
------------

// File: rtl/datmem_arbiter.sv
// datmem_arbiter: two-port (CPU=0, DMA=1) round-robin arbiter in front of a single-port data memory.
// Latency: Req sampled in IDLE at T -> Gnt at T+1 (BUSY, memory access) -> RVal/RDat/Err at T+3.
// Backpressure: requesters hold Req/We/Addr/WDat until Gnt; one access per 3 cycles at most.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_reqN/i_weN/i_addrN/i_wdatN   port N request, write select, word address, write data
//   o_gntN                  one-cycle accept pulse (coincides with the BUSY cycle)
//   o_rvalN/o_rdatN/o_errN  one-cycle completion pulse, read data, out-of-range flag (held)
//   o_mem_we/o_mem_addr/o_mem_wdat/i_mem_rdat   data-memory port (registered read, 1-cycle)
module datmem_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [AWIDTH-1:0] i_addr0,
  input  logic [AWIDTH-1:0] i_wdat0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [AWIDTH-1:0] i_addr1,
  input  logic [AWIDTH-1:0] i_wdat1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rval0,
  output logic              o_rval1,
  output logic [AWIDTH-1:0] o_rdat0,
  output logic [AWIDTH-1:0] o_rdat1,
  output logic              o_err0,
  output logic              o_err1,
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [AWIDTH-1:0] o_mem_wdat,
  input  logic [AWIDTH-1:0] i_mem_rdat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // One extra bit so an ALENGTH equal to 2**AWIDTH still compares correctly.
  localparam logic [AWIDTH:0] LP_ALEN = (AWIDTH+1)'(ALENGTH);

  state_t r_state;
  logic   r_last_gnt;  // port granted most recently; also the owner of the in-flight access
  logic   r_we;        // latched write select of the in-flight access

  logic w_any_req;
  logic w_win;
  logic w_in_range;

  assign w_any_req = i_req0 | i_req1;

  // Single requester wins outright; on contention the port that did not win last time goes.
  assign w_win = (i_req0 & i_req1) ? ~r_last_gnt : i_req1;

  // o_mem_addr holds the latched address for the whole access, so it doubles as the range source.
  assign w_in_range = ({1'b0, o_mem_addr} < LP_ALEN);

  // Combinational so that reset suppresses the write in the very cycle it is asserted.
  assign o_mem_we = (r_state == S_BUSY) & r_we & w_in_range & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_we       <= 1'b0;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_rval0    <= 1'b0;
      o_rval1    <= 1'b0;
      o_rdat0    <= '0;
      o_rdat1    <= '0;
      o_err0     <= 1'b0;
      o_err1     <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdat <= '0;
    end else begin
      o_gnt0  <= 1'b0;
      o_gnt1  <= 1'b0;
      o_rval0 <= 1'b0;
      o_rval1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_BUSY;
            r_last_gnt <= w_win;
            r_we       <= w_win ? i_we1   : i_we0;
            o_mem_addr <= w_win ? i_addr1 : i_addr0;
            o_mem_wdat <= w_win ? i_wdat1 : i_wdat0;
            o_gnt0     <= ~w_win;
            o_gnt1     <= w_win;
          end
        end
        S_BUSY: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          // i_mem_rdat now reflects the address presented during BUSY.
          r_state <= S_IDLE;
          if (r_last_gnt) begin
            o_rval1 <= 1'b1;
            o_err1  <= ~w_in_range;
            if (!w_in_range) begin
              o_rdat1 <= '0;
            end else if (!r_we) begin
              o_rdat1 <= i_mem_rdat;
            end
          end else begin
            o_rval0 <= 1'b1;
            o_err0  <= ~w_in_range;
            if (!w_in_range) begin
              o_rdat0 <= '0;
            end else if (!r_we) begin
              o_rdat0 <= i_mem_rdat;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datmem_arbiter.sv
module tb_datmem_arbiter;
  localparam int AW = 32;
  localparam int AL = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1, wdat0, wdat1;
  logic          gnt0, gnt1, rval0, rval1, err0, err1;
  logic [AW-1:0] rdat0, rdat1;
  logic          mem_we;
  logic [AW-1:0] mem_addr, mem_wdat, mem_rdat;

  datmem_arbiter #(.AWIDTH(AW), .ALENGTH(AL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdat0(wdat0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdat1(wdat1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rval0(rval0), .o_rval1(rval1),
    .o_rdat0(rdat0), .o_rdat1(rdat1), .o_err0(err0), .o_err1(err1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdat(mem_wdat),
    .i_mem_rdat(mem_rdat)
  );

  // Data memory model: registered read, one-cycle latency; initialised once, not by rst.
  logic [AW-1:0] mem [0:AL-1];
  logic          tb_init;
  int            n_oor_we = 0;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < AL; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_we && mem_addr < AW'(AL)) begin
      mem[mem_addr[6:0]] <= mem_wdat;
    end
    if (mem_addr < AW'(AL)) mem_rdat <= mem[mem_addr[6:0]];
    else                    mem_rdat <= 32'hBAD0_BAD0;
    if (mem_we && mem_addr >= AW'(AL)) n_oor_we <= n_oor_we + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete access on one port, starting in an IDLE cycle (T); checks T+1, T+2, T+3.
  task automatic do_access(input string tag, input logic port, input logic we,
                           input logic [AW-1:0] addr, input logic [AW-1:0] wdat,
                           input logic [AW-1:0] exp_rdat, input logic exp_err,
                           input logic exp_mem_we);
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdat0 = wdat; end
    else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdat1 = wdat; end
    cyc();  // T+1: BUSY
    check({tag, ".gnt_t1"}, {gnt1, gnt0}, port ? 2'b10 : 2'b01);
    check({tag, ".mem_we_t1"}, mem_we, exp_mem_we);
    check({tag, ".mem_addr_t1"}, mem_addr, addr);
    check({tag, ".mem_wdat_t1"}, mem_wdat, wdat);
    check({tag, ".rval_t1"}, {rval1, rval0}, 2'b00);
    req0 = 1'b0;
    req1 = 1'b0;
    cyc();  // T+2: RESP
    check({tag, ".gnt_t2"}, {gnt1, gnt0}, 2'b00);
    check({tag, ".mem_we_t2"}, mem_we, 1'b0);
    check({tag, ".rval_t2"}, {rval1, rval0}, 2'b00);
    cyc();  // T+3: IDLE, result visible
    check({tag, ".rval_t3"}, {rval1, rval0}, port ? 2'b10 : 2'b01);
    check({tag, ".rdat_t3"}, port ? rdat1 : rdat0, exp_rdat);
    check({tag, ".err_t3"}, port ? err1 : err0, exp_err);
    check({tag, ".mem_we_t3"}, mem_we, 1'b0);
  endtask

  int   n_g;
  int   gcyc[4];
  logic gport[4];
  logic both_gnt;
  logic any_rval;

  initial begin
    tb_init = 1'b1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;
    cyc();
    tb_init = 1'b0;
    cyc();

    // Reset state, sampled while reset is still asserted.
    check("rst.gnt", {gnt1, gnt0}, 2'b00);
    check("rst.rval", {rval1, rval0}, 2'b00);
    check("rst.rdat0", rdat0, 32'h0);
    check("rst.rdat1", rdat1, 32'h0);
    check("rst.err", {err1, err0}, 2'b00);
    check("rst.mem_we", mem_we, 1'b0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdat", mem_wdat, 32'h0);
    rst = 1'b0;

    // Basic write then read-back on the CPU port; writes leave RDat unchanged.
    do_access("wr0_5", 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    do_access("rd0_5", 1'b0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access("rd1_7", 1'b1, 1'b0, 32'd7, 32'h0, 32'h1000_0007, 1'b0, 1'b0);

    // Out-of-range writes on DMA port: no memory write, Err=1, RDat=0.
    do_access("wr1_128", 1'b1, 1'b1, 32'd128, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
    check("iso.rdat0", rdat0, 32'hDEAD_BEEF);
    check("iso.err0", err0, 1'b0);
    do_access("wr1_hi", 1'b1, 1'b1, 32'h8000_0005, 32'h2222_2222, 32'h0, 1'b1, 1'b0);

    // High address bits must not alias to word 5; DMA error flag holds meanwhile.
    do_access("rd0_5b", 1'b0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("hold.err1", err1, 1'b1);
    check("hold.rdat1", rdat1, 32'h0);

    // Last valid address.
    do_access("rd1_127", 1'b1, 1'b0, 32'd127, 32'h0, 32'h1000_007F, 1'b0, 1'b0);
    do_access("wr1_127", 1'b1, 1'b1, 32'd127, 32'hA5A5_A5A5, 32'h1000_007F, 1'b0, 1'b1);
    do_access("rd1_127b", 1'b1, 1'b0, 32'd127, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);

    // Reset during BUSY aborts the write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdat0 = 32'hCAFE_F00D;
    cyc();
    check("abort.gnt0", gnt0, 1'b1);
    check("abort.mem_we_pre", mem_we, 1'b1);
    rst = 1'b1;
    #1;
    check("abort.mem_we_rst", mem_we, 1'b0);
    cyc();
    req0 = 1'b0;
    check("abort.gnt", {gnt1, gnt0}, 2'b00);
    check("abort.rval", {rval1, rval0}, 2'b00);
    check("abort.rdat0", rdat0, 32'h0);
    check("abort.rdat1", rdat1, 32'h0);
    check("abort.err", {err1, err0}, 2'b00);
    check("abort.mem_addr", mem_addr, 32'h0);
    check("abort.mem_wdat", mem_wdat, 32'h0);
    rst = 1'b0;
    any_rval = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      any_rval = any_rval | rval0 | rval1;
    end
    check("abort.no_rval", any_rval, 1'b0);
    do_access("rd0_9", 1'b0, 1'b0, 32'd9, 32'h0, 32'h1000_0009, 1'b0, 1'b0);

    // Both ports held high after reset: 0,1,0,1 at 3-cycle spacing.
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
    cyc();
    rst = 1'b0;
    n_g = 0;
    both_gnt = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (gnt0 && gnt1) both_gnt = 1'b1;
      if ((gnt0 || gnt1) && n_g < 4) begin
        gcyc[n_g] = i;
        gport[n_g] = gnt1;
        n_g++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("rr.count", n_g, 4);
    check("rr.both", both_gnt, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr.port%0d", k), gport[k], k[0]);
      check($sformatf("rr.cyc%0d", k), gcyc[k], 1 + 3 * k);
    end
    check("rr.rdat0", rdat0, 32'h1000_0001);
    check("rr.rdat1", rdat1, 32'h1000_0002);
    cyc();
    cyc();
    cyc();
    check("rr.drain_gnt", {gnt1, gnt0}, 2'b00);

    check("oor_writes", n_oor_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
